// File: rtl/display_scan_scheduler.sv
// Purpose: time-multiplexes a double-buffered 4-digit BCD frame onto 8-segment pins, with a blanking gap between digits.
// Latency: outputs are Moore-decoded from the current registers; an accepted frame is shown from the next idx-0 entry.
// Backpressure: wr_ready drops while a pending frame waits for its frame-boundary commit; a pending frame is never overwritten.
module display_scan_scheduler #(
    parameter int TICK_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic        lz_en,
    output logic [7:0]  Digitron_Out,
    output logic [3:0]  DigitronCS_Out,
    output logic        frame_start
);

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        act_data_q, act_data_d;
    logic [3:0]         act_dp_q, act_dp_d;
    logic [15:0]        pend_data_q, pend_data_d;
    logic [3:0]         pend_dp_q, pend_dp_d;
    logic               pend_full_q, pend_full_d;
    logic               frame_start_q, frame_start_d;

    logic               xfer;
    logic [3:0]         digit_val;
    logic [6:0]         seg_raw;
    logic               lz_blank;

    assign wr_ready    = !pend_full_q;
    assign xfer        = wr_valid && wr_ready;
    assign frame_start = frame_start_q;

    // State register; reset also discards the pending frame.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= ST_BLANK;
            idx_q         <= 2'd3;
            cnt_q         <= '0;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_full_q   <= pend_full_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Next-state: ON/BLANK dwell counting, digit advance, frame commit and write capture.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q + CNT_W'(1);
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_full_d   = pend_full_q;
        frame_start_d = 1'b0;

        case (state_q)
            ST_ON: begin
                if (cnt_q == CNT_W'(TICK_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    // Entering digit 0 is the frame boundary: the only point where the shown frame may change.
                    if (idx_q == 2'd3) begin
                        frame_start_d = 1'b1;
                        if (pend_full_q) begin
                            act_data_d  = pend_data_q;
                            act_dp_d    = pend_dp_q;
                            pend_full_d = 1'b0;
                        end
                    end
                end
            end
        endcase

        // xfer implies pending was empty, so it never collides with a commit that empties it.
        if (xfer) begin
            pend_data_d = wr_data;
            pend_dp_d   = wr_dp;
            pend_full_d = 1'b1;
        end
    end

    // Digit value, leading-zero detection and 7-segment decode for the selected digit.
    always_comb begin
        digit_val = act_data_q[idx_q*4 +: 4];
        case (idx_q)
            2'd1:    lz_blank = (act_data_q[15:4] == 12'h000);
            2'd2:    lz_blank = (act_data_q[15:8] == 8'h00);
            2'd3:    lz_blank = (act_data_q[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
        case (digit_val)
            4'd0:    seg_raw = 7'h3f;
            4'd1:    seg_raw = 7'h06;
            4'd2:    seg_raw = 7'h5b;
            4'd3:    seg_raw = 7'h4f;
            4'd4:    seg_raw = 7'h66;
            4'd5:    seg_raw = 7'h6d;
            4'd6:    seg_raw = 7'h7d;
            4'd7:    seg_raw = 7'h07;
            4'd8:    seg_raw = 7'h7f;
            4'd9:    seg_raw = 7'h6f;
            default: seg_raw = 7'h00;
        endcase
        if (lz_en && lz_blank) begin
            seg_raw = 7'h00;
        end
    end

    // Pin drive: one digit lit in ON, everything dark in BLANK.
    always_comb begin
        Digitron_Out   = 8'h00;
        DigitronCS_Out = 4'b1111;
        if (state_q == ST_ON) begin
            Digitron_Out   = {act_dp_q[idx_q], seg_raw};
            DigitronCS_Out = ~(4'b0001 << idx_q);
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

    logic        CLK;
    logic        RSTn;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic        lz_en;
    logic [7:0]  Digitron_Out;
    logic [3:0]  DigitronCS_Out;
    logic        frame_start;

    int checks;
    int failures;
    int k;

    display_scan_scheduler #(
        .TICK_CYCLES (8),
        .BLANK_CYCLES(2),
        .CNT_W       (4)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_dp         (wr_dp),
        .lz_en         (lz_en),
        .Digitron_Out  (Digitron_Out),
        .DigitronCS_Out(DigitronCS_Out),
        .frame_start   (frame_start)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Advance one clock; all sampling and driving happens on the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    // Hand-derived scan timing for TICK=8, BLANK=2: digit 0 first lit after the 2nd edge, 10-cycle digit slots.
    function automatic logic [3:0] exp_cs(input int kk);
        int m, d;
        if (kk < 2) return 4'b1111;
        m = (kk - 2) % 10;
        d = ((kk - 2) / 10) % 4;
        if (m < 8) return ~(4'b0001 << d);
        return 4'b1111;
    endfunction

    initial begin
        logic [3:0] cs;
        checks   = 0;
        failures = 0;
        k        = 0;
        RSTn     = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        wr_dp    = 4'b0000;
        lz_en    = 1'b0;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check("rst_seg", Digitron_Out, 8'h00);
        check("rst_cs", DigitronCS_Out, 4'b1111);
        check("rst_rdy", wr_ready, 1'b1);
        check("rst_fs", frame_start, 1'b0);

        // Idle scan: blank gap, then digits 0..3 with 8/2-cycle dwell
        RSTn = 1'b1;
        k    = 0;
        check("idle_cs0", DigitronCS_Out, 4'b1111);
        for (int i = 1; i <= 41; i++) begin
            tick();
            cs = exp_cs(k);
            check("idle_cs", DigitronCS_Out, cs);
            check("idle_seg", Digitron_Out, (cs == 4'b1111) ? 8'h00 : 8'h3f);
            check("idle_fs", frame_start, (k == 2) ? 1'b1 : 1'b0);
        end

        // Write 1234 in the blank just before idx 0: lands on the commit edge, so shown one frame later
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        wr_dp    = 4'b0100;
        tick();
        wr_valid = 1'b0;
        check("w1_fs", frame_start, 1'b1);
        check("w1_rdy", wr_ready, 1'b0);
        check("w1_old0", Digitron_Out, 8'h3f);
        run_to(82);
        check("w1_fs2", frame_start, 1'b1);
        check("w1_rdy2", wr_ready, 1'b1);
        check("w1_d0", Digitron_Out, 8'h66);
        check("w1_cs0", DigitronCS_Out, 4'b1110);
        run_to(92);
        check("w1_d1", Digitron_Out, 8'h4f);
        check("w1_cs1", DigitronCS_Out, 4'b1101);

        // Mid-frame write 5678; then hold valid with new data while full
        wr_valid = 1'b1;
        wr_data  = 16'h5678;
        wr_dp    = 4'b0000;
        tick();
        check("w2_rdy", wr_ready, 1'b0);
        wr_data = 16'h9999;
        wr_dp   = 4'b1111;
        run_to(100);
        wr_valid = 1'b0;
        run_to(102);
        check("w2_old_d2", Digitron_Out, 8'hdb);
        run_to(112);
        check("w2_old_d3", Digitron_Out, 8'h06);
        run_to(121);
        check("w2_rdy_pre", wr_ready, 1'b0);
        tick();
        check("w2_rdy_commit", wr_ready, 1'b1);
        check("w2_fs", frame_start, 1'b1);
        check("w2_d0", Digitron_Out, 8'h7f);
        run_to(132);
        check("w2_d1", Digitron_Out, 8'h07);
        run_to(142);
        check("w2_d2", Digitron_Out, 8'h7d);
        run_to(152);
        check("w2_d3", Digitron_Out, 8'h6d);

        // Leading-zero suppression on 0040 with a DP on the suppressed top digit
        wr_valid = 1'b1;
        wr_data  = 16'h0040;
        wr_dp    = 4'b1000;
        tick();
        wr_valid = 1'b0;
        lz_en    = 1'b1;
        run_to(162);
        check("lz_d0", Digitron_Out, 8'h3f);
        run_to(172);
        check("lz_d1", Digitron_Out, 8'h66);
        run_to(182);
        check("lz_d2", Digitron_Out, 8'h00);
        run_to(192);
        check("lz_d3", Digitron_Out, 8'h80);
        check("lz_cs3", DigitronCS_Out, 4'b0111);
        lz_en    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 16'h000A;
        wr_dp    = 4'b0000;
        tick();
        wr_valid = 1'b0;
        check("nolz_d3", Digitron_Out, 8'hbf);
        run_to(202);
        check("hex_d0", Digitron_Out, 8'h00);
        check("hex_cs0", DigitronCS_Out, 4'b1110);
        run_to(212);
        check("nolz_d1", Digitron_Out, 8'h3f);

        // Reset during idx 2 ON with a pending frame
        wr_valid = 1'b1;
        wr_data  = 16'h1111;
        wr_dp    = 4'b1111;
        tick();
        wr_valid = 1'b0;
        run_to(225);
        check("mr_pre_rdy", wr_ready, 1'b0);
        check("mr_pre_cs", DigitronCS_Out, 4'b1011);
        RSTn = 1'b0;
        #1;
        check("mr_seg", Digitron_Out, 8'h00);
        check("mr_cs", DigitronCS_Out, 4'b1111);
        check("mr_rdy", wr_ready, 1'b1);
        @(negedge CLK);
        RSTn = 1'b1;
        k    = 0;
        run_to(2);
        check("mr_fs", frame_start, 1'b1);
        check("mr_d0", Digitron_Out, 8'h3f);
        run_to(22);
        check("mr_d2", Digitron_Out, 8'h3f);
        run_to(42);
        check("mr_fs2", frame_start, 1'b1);
        check("mr_discard_d0", Digitron_Out, 8'h3f);
        run_to(52);
        check("mr_discard_d1", Digitron_Out, 8'h3f);
        check("mr_cs1", DigitronCS_Out, 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
